// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl
// Frame sequencer for a rate-1/2 convolutional encoder datapath. It accepts a
// parallel frame and serialises it MSB first into the encoder. It then appends
// TAIL_LEN zero bits so the encoder finishes in the all-zero state. Every
// encoder symbol is packed into one codeword, which is offered downstream.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_frame_valid/i_frame upstream frame offer; bit FRAME_LEN-1 is sent first
//   o_frame_ready         high only in IDLE
//   o_enc_start/o_enc_data registered drive of the encoder's i_start/i_data
//   i_enc_valid/i_enc_data encoder output symbol stream
//   o_code_valid/o_code   packed codeword (first symbol in the MSBs)
//   i_code_ready          downstream accept
//   o_busy                high in every state except IDLE
module conv_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned TAIL_LEN  = 2,
  parameter int unsigned SIZE_OUT  = 2,
  parameter int unsigned CODE_W    = SIZE_OUT * (FRAME_LEN + TAIL_LEN)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_frame_valid,
  input  logic [FRAME_LEN-1:0] i_frame,
  output logic                 o_frame_ready,
  output logic                 o_enc_start,
  output logic                 o_enc_data,
  input  logic                 i_enc_valid,
  input  logic [SIZE_OUT-1:0]  i_enc_data,
  output logic                 o_code_valid,
  output logic [CODE_W-1:0]    o_code,
  input  logic                 i_code_ready,
  output logic                 o_busy
);

  localparam int unsigned N_SYM = FRAME_LEN + TAIL_LEN;
  localparam int unsigned CNT_W = $clog2(N_SYM + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_DATA,
    SEND_TAIL,
    DRAIN,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     sym_cnt_q, sym_cnt_d;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic                 enc_start_q, enc_start_d;
  logic                 enc_data_q, enc_data_d;
  logic                 code_valid_q, code_valid_d;
  logic                 busy_q, busy_d;
  logic                 capture_en;

  // Symbols are only collected while a frame is in flight and until the
  // expected count is reached; late or stray pulses are dropped.
  always_comb begin
    capture_en = i_enc_valid
                 && ((state_q == SEND_DATA) || (state_q == SEND_TAIL) || (state_q == DRAIN))
                 && (sym_cnt_q < CNT_W'(N_SYM));
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sym_cnt_d = sym_cnt_q;
    shreg_d   = shreg_q;
    code_d    = code_q;

    if (capture_en) begin
      code_d    = (code_q << SIZE_OUT) | CODE_W'(i_enc_data);
      sym_cnt_d = sym_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (i_frame_valid) begin
          shreg_d   = i_frame;
          bit_cnt_d = '0;
          sym_cnt_d = '0;
          state_d   = SEND_DATA;
        end
      end
      SEND_DATA: begin
        shreg_d = shreg_q << 1;
        if (bit_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          bit_cnt_d = '0;
          state_d   = (TAIL_LEN == 0) ? DRAIN : SEND_TAIL;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      SEND_TAIL: begin
        if (bit_cnt_q == CNT_W'(TAIL_LEN - 1)) begin
          bit_cnt_d = '0;
          state_d   = DRAIN;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        // Uses the post-capture count so the final symbol's edge also exits.
        if (sym_cnt_d == CNT_W'(N_SYM)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_code_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state, so the state register and
    // the encoder drive always describe the same cycle.
    enc_start_d  = (state_d == SEND_DATA) || (state_d == SEND_TAIL);
    enc_data_d   = (state_d == SEND_DATA) && shreg_d[FRAME_LEN-1];
    code_valid_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      sym_cnt_q    <= '0;
      shreg_q      <= '0;
      code_q       <= '0;
      enc_start_q  <= 1'b0;
      enc_data_q   <= 1'b0;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      shreg_q      <= shreg_d;
      code_q       <= code_d;
      enc_start_q  <= enc_start_d;
      enc_data_q   <= enc_data_d;
      code_valid_q <= code_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign o_frame_ready = (state_q == IDLE);
  assign o_enc_start   = enc_start_q;
  assign o_enc_data    = enc_data_q;
  assign o_code_valid  = code_valid_q;
  assign o_code        = code_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Testbench for conv_frame_ctrl. It drives the controller together with a
// (7,5) K=3 rate-1/2 encoder (one cycle output latency, shares i_rst).
module tb_conv_frame_ctrl;

  localparam int unsigned FL  = 8;
  localparam int unsigned TL  = 2;
  localparam int unsigned SO  = 2;
  localparam int unsigned NS  = FL + TL;
  localparam int unsigned CW  = SO * NS;
  localparam int          LAT = 1 + FL + TL + 1;   // encoder latency 1

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_frame_valid = 1'b0;
  logic [FL-1:0] i_frame = '0;
  logic          i_code_ready = 1'b0;
  logic          o_frame_ready, o_enc_start, o_enc_data, o_code_valid, o_busy;
  logic [CW-1:0] o_code;

  // Encoder model and stray-pulse injection
  logic [1:0]    enc_st;      // [0] = previous bit, [1] = bit before that
  logic          enc_v;
  logic [SO-1:0] enc_d;
  logic          inj_valid = 1'b0;
  logic [SO-1:0] inj_data = '0;
  logic          dut_enc_valid;
  logic [SO-1:0] dut_enc_data;

  int total = 0;
  int bad   = 0;
  logic [CW-1:0] last_code;
  bit noise = 1'b0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_st <= '0;
      enc_v  <= 1'b0;
      enc_d  <= '0;
    end else begin
      enc_v <= o_enc_start;
      if (o_enc_start) begin
        enc_d  <= {o_enc_data ^ enc_st[0] ^ enc_st[1], o_enc_data ^ enc_st[1]};
        enc_st <= {enc_st[0], o_enc_data};
      end
    end
  end

  assign dut_enc_valid = enc_v | inj_valid;
  assign dut_enc_data  = inj_valid ? inj_data : enc_d;

  conv_frame_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(TL), .SIZE_OUT(SO)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_valid (i_frame_valid),
    .i_frame       (i_frame),
    .o_frame_ready (o_frame_ready),
    .o_enc_start   (o_enc_start),
    .o_enc_data    (o_enc_data),
    .i_enc_valid   (dut_enc_valid),
    .i_enc_data    (dut_enc_data),
    .o_code_valid  (o_code_valid),
    .o_code        (o_code),
    .i_code_ready  (i_code_ready),
    .o_busy        (o_busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: convolve the bit sequence (frame MSB first, then zeros) with
  // generators 111 and 101, packing symbols {g0,g1} from the MSB end.
  function automatic logic [CW-1:0] ref_code(input logic [FL-1:0] f);
    int b[NS];
    int p1, p2, g0, g1;
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NS; i++) b[i] = (i < FL) ? int'(f[FL-1-i]) : 0;
    for (int i = 0; i < NS; i++) begin
      p1 = (i >= 1) ? b[i-1] : 0;
      p2 = (i >= 2) ? b[i-2] : 0;
      g0 = (b[i] + p1 + p2) % 2;
      g1 = (b[i] + p2) % 2;
      c  = (c << 2) | CW'(g0 * 2 + g1);
    end
    return c;
  endfunction

  // Called in cycle 1 after the accepting edge; returns when o_code_valid is
  // seen. lat counts cycles from the handshake cycle.
  task automatic collect(output logic [CW-1:0] code, output int lat,
                         output int starts, output logic [NS-1:0] bits);
    starts = 0;
    bits   = '0;
    lat    = 1;
    while (!o_code_valid && lat < 60) begin
      if (o_enc_start) begin
        bits = {bits[NS-2:0], o_enc_data};
        starts++;
      end
      @(posedge clk); #1;
      lat++;
    end
    code = o_code;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_frame_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 32'(n < 50), 32'd1);
  endtask

  task automatic do_frame(input logic [FL-1:0] f, input logic [CW-1:0] exp_code,
                          input bit rdy_early, input int hold);
    logic [CW-1:0] code;
    logic [NS-1:0] bits;
    logic [NS-1:0] exp_bits;
    int lat, starts;
    bit stable;
    exp_bits = {f, {TL{1'b0}}};
    wait_ready();
    i_frame = f;
    i_frame_valid = 1'b1;
    @(posedge clk); #1;
    i_frame_valid = 1'b0;
    i_frame = FL'($urandom);
    chk("after_accept", {29'd0, o_busy, o_frame_ready, o_enc_start}, 32'b101);
    if (rdy_early) i_code_ready = 1'b1;
    collect(code, lat, starts, bits);
    chk("code", 32'(code), 32'(exp_code));
    chk("latency", 32'(lat), 32'(LAT));
    chk("start_cycles", 32'(starts), 32'(NS));
    chk("enc_bits", 32'(bits), 32'(exp_bits));
    if (!rdy_early) begin
      if (hold > 0) begin
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
          if (noise) begin
            i_frame_valid = 1'b1;
            i_frame = FL'($urandom);
            inj_valid = 1'($urandom);
            inj_data = SO'($urandom);
          end
          @(posedge clk); #1;
          if (!(o_code_valid && o_code === exp_code && !o_frame_ready && o_busy)) stable = 1'b0;
        end
        i_frame_valid = 1'b0;
        inj_valid = 1'b0;
        chk("hold_stable", 32'(stable), 32'd1);
      end
      i_code_ready = 1'b1;
    end
    @(posedge clk); #1;
    i_code_ready = 1'b0;
    chk("release", {29'd0, o_code_valid, o_frame_ready, o_busy}, 32'b010);
    last_code = exp_code;
  endtask

  typedef struct {
    logic [FL-1:0] frame;
    logic [CW-1:0] code;
    bit            rdy_early;
    int            hold;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [CW-1:0] code;
    logic [NS-1:0] bits;
    logic [FL-1:0] fa, fb, rf;
    int lat, starts;
    bit quiet;

    tbl[0] = '{8'b11011010, 20'b11010100010100101100, 1'b1, 0};
    tbl[1] = '{8'b10101010, 20'b11100010001000101100, 1'b0, 3};
    tbl[2] = '{8'b00000001, 20'b00000000000000111011, 1'b0, 1};
    tbl[3] = '{8'b00000000, 20'b00000000000000000000, 1'b1, 0};
    tbl[4] = '{8'b11111111, 20'b11011010101010100111, 1'b0, 2};

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("reset_outputs", {27'd0, o_frame_ready, o_enc_start, o_enc_data, o_code_valid, o_busy}, 32'b10000);
    chk("reset_code", 32'(o_code), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    last_code = '0;
    @(posedge clk); #1;

    // Table-driven frames
    for (int i = 0; i < 5; i++) do_frame(tbl[i].frame, tbl[i].code, tbl[i].rdy_early, tbl[i].hold);

    // Back-to-back: valid held high across two frames, ready held high
    fa = 8'b11011010;
    fb = 8'b00000001;
    wait_ready();
    i_frame = fa;
    i_frame_valid = 1'b1;
    i_code_ready = 1'b1;
    @(posedge clk); #1;
    i_frame = fb;
    collect(code, lat, starts, bits);
    chk("b2b_code_a", 32'(code), 32'(ref_code(fa)));
    chk("b2b_lat_a", 32'(lat), 32'(LAT));
    @(posedge clk); #1;
    chk("b2b_bubble", {29'd0, o_frame_ready, o_code_valid, o_busy}, 32'b100);
    @(posedge clk); #1;
    i_frame_valid = 1'b0;
    chk("b2b_second_start", {29'd0, o_enc_start, o_enc_data, o_busy}, {29'd0, 1'b1, fb[FL-1], 1'b1});
    chk("b2b_flush_state", 32'(enc_st), 32'd0);
    collect(code, lat, starts, bits);
    chk("b2b_code_b", 32'(code), 32'(ref_code(fb)));
    chk("b2b_lat_b", 32'(lat), 32'(LAT));
    @(posedge clk); #1;
    i_code_ready = 1'b0;
    chk("b2b_one_cycle_valid", {30'd0, o_code_valid, o_frame_ready}, 32'b01);

    // Backpressure with frame offers and stray symbols while in DONE
    noise = 1'b1;
    do_frame(8'b10101010, 20'b11100010001000101100, 1'b0, 20);
    noise = 1'b0;
    do_frame(8'b11011010, 20'b11010100010100101100, 1'b0, 1);

    // Reset mid-frame after four data bits
    wait_ready();
    i_frame = 8'b11011010;
    i_frame_valid = 1'b1;
    @(posedge clk); #1;
    i_frame_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_outputs", {27'd0, o_frame_ready, o_enc_start, o_enc_data, o_code_valid, o_busy}, 32'b10000);
    chk("midrst_code", 32'(o_code), 32'd0);
    @(negedge clk) rst = 1'b0;
    last_code = '0;
    @(posedge clk); #1;
    do_frame(8'b11011010, 20'b11010100010100101100, 1'b0, 0);

    // Stray encoder pulses while idle
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      inj_valid = 1'b1;
      inj_data = SO'($urandom);
      @(posedge clk); #1;
      if (!(o_code === last_code && !o_code_valid && o_frame_ready && !o_busy)) quiet = 1'b0;
    end
    inj_valid = 1'b0;
    chk("idle_stray_pulses", 32'(quiet), 32'd1);
    do_frame(8'b00000001, 20'b00000000000000111011, 1'b0, 0);

    // Randomized frames against the reference model
    for (int i = 0; i < 25; i++) begin
      rf = FL'($urandom);
      do_frame(rf, ref_code(rf), 1'($urandom), $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
